// File: rtl/game_scene_ctrl.sv
// BuildingDrops game-flow controller: TITLE/PLAY/OVER scene FSM with a
// debounced start button, lives and tower-height tracking.
module game_scene_ctrl #(
    parameter int LIVES      = 3,
    parameter int OVER_TICKS = 100,
    parameter int DEBOUNCE   = 4
) (
    input  logic       work_clk,
    input  logic       rst,
    input  logic       btn_start,
    input  logic       drop_ok,
    input  logic       drop_miss,
    output logic [1:0] scene,
    output logic [3:0] lives_left,
    output logic [7:0] tower_height,
    output logic       new_game
);

    localparam int DW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
    localparam int TW = (OVER_TICKS > 1) ? $clog2(OVER_TICKS) : 1;
    localparam logic [DW-1:0] DB_LAST    = DW'(DEBOUNCE - 1);
    localparam logic [TW-1:0] T_LAST     = TW'(OVER_TICKS - 1);
    localparam logic [3:0]    LIVES_INIT = 4'(LIVES);

    typedef enum logic [1:0] {
        S_TITLE = 2'd0,
        S_PLAY  = 2'd1,
        S_OVER  = 2'd2
    } state_t;

    logic [1:0]    sync_q;
    logic [DW-1:0] db_cnt;
    logic          db_level;
    logic          db_prev;
    logic          press;

    state_t        state_q, state_d;
    logic [3:0]    lives_q, lives_d;
    logic [7:0]    height_q, height_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          new_game_q, new_game_d;

    // Level only moves after DEBOUNCE consecutive disagreeing samples.
    always_ff @(posedge work_clk) begin
        if (rst) begin
            sync_q   <= 2'b00;
            db_cnt   <= '0;
            db_level <= 1'b0;
            db_prev  <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], btn_start};
            db_prev <= db_level;
            if (sync_q[1] == db_level) begin
                db_cnt <= '0;
            end else if (db_cnt == DB_LAST) begin
                db_level <= sync_q[1];
                db_cnt   <= '0;
            end else begin
                db_cnt <= db_cnt + 1'b1;
            end
        end
    end

    assign press = db_level & ~db_prev;

    always_ff @(posedge work_clk) begin
        if (rst) begin
            state_q    <= S_TITLE;
            lives_q    <= 4'd0;
            height_q   <= 8'd0;
            timer_q    <= '0;
            new_game_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            lives_q    <= lives_d;
            height_q   <= height_d;
            timer_q    <= timer_d;
            new_game_q <= new_game_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        lives_d    = lives_q;
        height_d   = height_q;
        timer_d    = timer_q;
        new_game_d = 1'b0;
        case (state_q)
            S_TITLE: begin
                if (press) begin
                    state_d    = S_PLAY;
                    lives_d    = LIVES_INIT;
                    height_d   = 8'd0;
                    new_game_d = 1'b1;
                end
            end
            S_PLAY: begin
                // A miss in the same cycle as a landing takes priority.
                if (drop_miss) begin
                    if (lives_q <= 4'd1) begin
                        lives_d = 4'd0;
                        state_d = S_OVER;
                        timer_d = '0;
                    end else begin
                        lives_d = lives_q - 4'd1;
                    end
                end else if (drop_ok && height_q != 8'hFF) begin
                    height_d = height_q + 8'd1;
                end
            end
            S_OVER: begin
                if (press || timer_q == T_LAST) begin
                    state_d = S_TITLE;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            default: state_d = S_TITLE;
        endcase
    end

    assign scene        = state_q;
    assign lives_left   = lives_q;
    assign tower_height = height_q;
    assign new_game     = new_game_q;

endmodule

// File: tb/tb_game_scene_ctrl.sv
// Directed self-checking bench for game_scene_ctrl (LIVES=3,
// OVER_TICKS=100, DEBOUNCE=4).
module tb_game_scene_ctrl;

    logic       work_clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn_start = 1'b0;
    logic       drop_ok = 1'b0;
    logic       drop_miss = 1'b0;
    logic [1:0] scene;
    logic [3:0] lives_left;
    logic [7:0] tower_height;
    logic       new_game;

    int checks = 0;
    int errors = 0;
    int ng_seen;

    game_scene_ctrl #(
        .LIVES(3),
        .OVER_TICKS(100),
        .DEBOUNCE(4)
    ) dut (
        .work_clk(work_clk),
        .rst(rst),
        .btn_start(btn_start),
        .drop_ok(drop_ok),
        .drop_miss(drop_miss),
        .scene(scene),
        .lives_left(lives_left),
        .tower_height(tower_height),
        .new_game(new_game)
    );

    always #5 work_clk = ~work_clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance one edge and settle away from it; counts new_game pulses.
    task automatic tick();
        @(posedge work_clk);
        #1;
        if (new_game === 1'b1) ng_seen++;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Press start from TITLE: scene reads PLAY on the 7th edge.
    task automatic start_game(input string tag);
        btn_start = 1'b1;
        ticks(6);
        check({tag, "_pre_scene"}, scene, 0);
        tick();
        check({tag, "_scene"}, scene, 1);
        check({tag, "_new_game"}, new_game, 1);
        check({tag, "_lives"}, lives_left, 3);
        check({tag, "_height"}, tower_height, 0);
        btn_start = 1'b0;
        ticks(8);
    endtask

    task automatic miss();
        drop_miss = 1'b1;
        tick();
        drop_miss = 1'b0;
    endtask

    initial begin
        ng_seen = 0;
        ticks(2);
        rst = 1'b0;
        check("rst_scene", scene, 0);
        check("rst_lives", lives_left, 0);
        check("rst_height", tower_height, 0);
        check("rst_new_game", new_game, 0);
        ticks(10);
        check("idle_scene", scene, 0);
        check("idle_lives", lives_left, 0);
        check("idle_new_game", ng_seen, 0);

        // Held button: one game start only
        ng_seen = 0;
        btn_start = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            tick();
            if (i == 6) check("hold_pre_scene", scene, 0);
            if (i == 7) begin
                check("hold_scene", scene, 1);
                check("hold_new_game", new_game, 1);
                check("hold_lives", lives_left, 3);
                check("hold_height", tower_height, 0);
            end
            if (i == 8) check("hold_ng_drop", new_game, 0);
        end
        btn_start = 1'b0;
        ticks(8);
        check("hold_one_pulse", ng_seen, 1);

        for (int i = 0; i < 5; i++) begin
            drop_ok = 1'b1;
            tick();
            drop_ok = 1'b0;
            tick();
        end
        check("five_ok_height", tower_height, 5);
        drop_ok = 1'b1;
        drop_miss = 1'b1;
        tick();
        drop_ok = 1'b0;
        drop_miss = 1'b0;
        check("both_height", tower_height, 5);
        check("both_lives", lives_left, 2);
        check("both_scene", scene, 1);

        miss();
        check("miss1_lives", lives_left, 1);
        check("miss1_scene", scene, 1);
        miss();
        check("over_scene", scene, 2);
        check("over_lives", lives_left, 0);
        check("over_height", tower_height, 5);
        for (int i = 0; i < 99; i++) begin
            drop_ok = (i < 3);
            drop_miss = (i < 3);
            tick();
        end
        drop_ok = 1'b0;
        drop_miss = 1'b0;
        check("over_99_scene", scene, 2);
        check("over_99_height", tower_height, 5);
        tick();
        check("timeout_scene", scene, 0);
        check("timeout_height", tower_height, 5);
        check("timeout_lives", lives_left, 0);
        drop_ok = 1'b1;
        tick();
        drop_ok = 1'b0;
        tick();
        check("title_drop_height", tower_height, 5);

        // Early exit from OVER by pressing start
        start_game("g2");
        miss();
        miss();
        miss();
        check("g2_over_scene", scene, 2);
        ticks(3);
        btn_start = 1'b1;
        ticks(6);
        check("early_pre_scene", scene, 2);
        tick();
        check("early_scene", scene, 0);
        check("early_height", tower_height, 0);
        btn_start = 1'b0;
        ticks(8);

        // Glitches shorter than the debounce window
        ng_seen = 0;
        for (int i = 0; i < 5; i++) begin
            btn_start = 1'b1;
            tick();
            btn_start = 1'b0;
            tick();
        end
        btn_start = 1'b1;
        ticks(3);
        btn_start = 1'b0;
        ticks(12);
        check("glitch_scene", scene, 0);
        check("glitch_new_game", ng_seen, 0);

        start_game("g3");
        drop_ok = 1'b1;
        ticks(254);
        check("sat_254", tower_height, 254);
        tick();
        check("sat_255", tower_height, 255);
        ticks(45);
        drop_ok = 1'b0;
        check("sat_hold", tower_height, 255);
        check("sat_scene", scene, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_scene", scene, 0);
        check("midrst_height", tower_height, 0);
        check("midrst_lives", lives_left, 0);
        check("midrst_new_game", new_game, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
